// File: rtl/conv5x5_if.sv
// Column/status stream and coefficient port bundle for conv5x5_filter.
interface conv5x5_if;
    logic [7:0] pa;
    logic [7:0] pb;
    logic [7:0] pc;
    logic [7:0] pd;
    logic [7:0] pe;
    logic       stat_in;
    logic       coef_we;
    logic [4:0] coef_idx;
    logic [7:0] coef_din;
    logic       coef_commit;
    logic [7:0] pixel_o;
    logic       stat_o;

    modport master (
        output pa, pb, pc, pd, pe, stat_in,
        output coef_we, coef_idx, coef_din, coef_commit,
        input  pixel_o, stat_o
    );

    modport slave (
        input  pa, pb, pc, pd, pe, stat_in,
        input  coef_we, coef_idx, coef_din, coef_commit,
        output pixel_o, stat_o
    );
endinterface

// File: rtl/conv5x5_filter.sv
// Pipelined 5x5 convolution with round/shift/clamp to 8 bits.
// Coefficient write/commit logic is compiled in with CONV_COEF_WR_EN.
module conv5x5_filter #(
    parameter int SHIFT = 4
) (
    input logic       clk,
    input logic       rst,
    conv5x5_if.slave  bus
);
    localparam logic signed [7:0] CENTRE =
        (SHIFT >= 7) ? 8'sd127 : 8'((1 << SHIFT));
    localparam logic signed [22:0] RND = 23'(((1 << SHIFT) >> 1));

    function automatic logic signed [7:0] ident(input int i);
        return (i == 12) ? CENTRE : 8'sd0;
    endfunction

    function automatic logic signed [16:0] mul(
        input logic [7:0]        px,
        input logic signed [7:0] k
    );
        return 17'($signed({1'b0, px})) * 17'(k);
    endfunction

    logic [7:0]         col   [5];
    logic [7:0]         win   [5][5];
    logic signed [16:0] prod  [5][5];
    logic signed [19:0] rows  [5];
    logic signed [21:0] total;
    logic signed [22:0] rnd;
    logic signed [22:0] shf;
    logic [7:0]         pix_n;
    logic [5:0]         stat_d;
    logic signed [7:0]  act   [25];

    always_comb begin
        col[0] = bus.pa;
        col[1] = bus.pb;
        col[2] = bus.pc;
        col[3] = bus.pd;
        col[4] = bus.pe;
    end

`ifdef CONV_COEF_WR_EN
    logic signed [7:0] shd [25];

    // commit copies the pre-write shadow: both sides sample old values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 25; i++) begin
                shd[i] <= ident(i);
                act[i] <= ident(i);
            end
        end else begin
            if (bus.coef_commit) begin
                for (int i = 0; i < 25; i++) act[i] <= shd[i];
            end
            if (bus.coef_we && (bus.coef_idx < 5'd25)) begin
                shd[bus.coef_idx] <= bus.coef_din;
            end
        end
    end
`else
    logic unused_coef;
    assign unused_coef = ^{bus.coef_we, bus.coef_idx,
                           bus.coef_din, bus.coef_commit};

    always_comb begin
        for (int i = 0; i < 25; i++) act[i] = ident(i);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win[r][c]  <= '0;
                    prod[r][c] <= '0;
                end
                rows[r] <= '0;
            end
            total <= '0;
        end else begin
            for (int r = 0; r < 5; r++) begin
                win[r][0] <= col[r];
                for (int c = 1; c < 5; c++) begin
                    win[r][c] <= win[r][c-1];
                end
                for (int c = 0; c < 5; c++) begin
                    prod[r][c] <= mul(win[r][c], act[r*5+c]);
                end
                rows[r] <= 20'(prod[r][0]) + 20'(prod[r][1])
                         + 20'(prod[r][2]) + 20'(prod[r][3])
                         + 20'(prod[r][4]);
            end
            total <= 22'(rows[0]) + 22'(rows[1]) + 22'(rows[2])
                   + 22'(rows[3]) + 22'(rows[4]);
        end
    end

    always_comb begin
        rnd   = 23'(total) + RND;
        shf   = rnd >>> SHIFT;
        pix_n = shf[7:0];
        if (shf < 23'sd0) begin
            pix_n = 8'h00;
        end else if (shf > 23'sd255) begin
            pix_n = 8'hff;
        end
    end

    // status needs one flop per pixel stage, pixel_o included
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_d      <= '0;
            bus.stat_o  <= 1'b0;
            bus.pixel_o <= '0;
        end else begin
            stat_d      <= {stat_d[4:0], bus.stat_in};
            bus.stat_o  <= stat_d[5];
            bus.pixel_o <= pix_n;
        end
    end
endmodule

// File: tb/tb_conv5x5_filter.sv
// Randomized self-checking bench for conv5x5_filter against a
// history-based convolution model.
module tb_conv5x5_filter;
    localparam int SHIFT = 4;
    localparam int NE    = 4096;
`ifdef CONV_COEF_WR_EN
    localparam bit WR = 1'b1;
`else
    localparam bit WR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    conv5x5_if bus ();

    conv5x5_filter #(.SHIFT(SHIFT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    int e;
    int colh  [NE][5];
    bit sth   [NE];
    int acth  [NE][25];
    int shadow [25];
    int active [25];
    int pix_mode  = 0;
    int stat_mode = 0;

    function automatic int ident(input int i);
        if (i != 12) return 0;
        return (SHIFT >= 7) ? 127 : (1 << SHIFT);
    endfunction

    function automatic int colv(input int t, input int r);
        return (t < 1) ? 0 : colh[t][r];
    endfunction

    function automatic int actk(input int t, input int i);
        return (t < 1) ? ident(i) : acth[t][i];
    endfunction

    // pixel after edge n: window of edge n-4, bank active after edge n-4
    function automatic int exp_pix(input int n);
        int s;
        s = 0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++)
                s += colv(n - 4 - c, r) * actk(n - 4, r * 5 + c);
        s = (s + ((1 << SHIFT) >> 1)) >>> SHIFT;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic int exp_stat(input int n);
        return (n - 6 < 1) ? 0 : int'(sth[n - 6]);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            e = 0;
            for (int i = 0; i < 25; i++) begin
                shadow[i] = ident(i);
                active[i] = ident(i);
            end
        end else begin
`ifdef CONV_COEF_WR_EN
            int old [25];
            old = shadow;
            if (bus.coef_we && bus.coef_idx < 25)
                shadow[bus.coef_idx] = int'($signed(bus.coef_din));
            if (bus.coef_commit) active = old;
`endif
            e++;
            colh[e][0] = bus.pa;
            colh[e][1] = bus.pb;
            colh[e][2] = bus.pc;
            colh[e][3] = bus.pd;
            colh[e][4] = bus.pe;
            sth[e]     = bus.stat_in;
            for (int i = 0; i < 25; i++) acth[e][i] = active[i];
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            int ep, es;
            ep = exp_pix(e);
            es = exp_stat(e);
            checks++;
            if (int'(bus.pixel_o) != ep || int'(bus.stat_o) != es) begin
                failures++;
                $display("FAIL stream edge=%0d pixel=%0d stat=%0d want pixel=%0d stat=%0d",
                         e, bus.pixel_o, bus.stat_o, ep, es);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic step(input bit we, input int idx, input int din,
                        input bit cm);
        @(negedge clk);
        bus.coef_we     = we;
        bus.coef_idx    = 5'(idx);
        bus.coef_din    = 8'(din);
        bus.coef_commit = cm;
        if (pix_mode < 0) begin
            bus.pa = 8'($urandom);
            bus.pb = 8'($urandom);
            bus.pc = 8'($urandom);
            bus.pd = 8'($urandom);
            bus.pe = 8'($urandom);
        end else begin
            bus.pa = 8'(pix_mode);
            bus.pb = 8'(pix_mode);
            bus.pc = 8'(pix_mode);
            bus.pd = 8'(pix_mode);
            bus.pe = 8'(pix_mode);
        end
        bus.stat_in = (stat_mode < 0) ? 1'($urandom) : 1'(stat_mode);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 0, 1'b0);
    endtask

    task automatic load_all(input int v);
        for (int i = 0; i < 25; i++) step(1'b1, i, v, 1'b0);
    endtask

    task automatic rand_coefs(input int n);
        int d;
        repeat (n) begin
            d = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 255)
                                            : $urandom_range(0, 8) - 4;
            step(1'($urandom_range(0, 1)), $urandom_range(0, 31), d,
                 ($urandom_range(0, 15) == 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.pa = '0; bus.pb = '0; bus.pc = '0; bus.pd = '0; bus.pe = '0;
        bus.stat_in = 1'b0;
        bus.coef_we = 1'b0; bus.coef_idx = '0;
        bus.coef_din = '0; bus.coef_commit = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pix", bus.pixel_o, 0);
        check("rst_stat", bus.stat_o, 0);
        rst = 1'b0;

        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (j == 20 || j == 39) begin
                check("ramp_pix", bus.pixel_o, j - 7);
                check("ramp_stat", bus.stat_o, (j - 7) & 1);
            end
            bus.pa = 8'(j); bus.pb = 8'(j); bus.pc = 8'(j);
            bus.pd = 8'(j); bus.pe = 8'(j);
            bus.stat_in = 1'(j & 1);
        end

        pix_mode = -1; stat_mode = -1;
        idle(100);

        pix_mode = 16;
        load_all(1);
        step(1'b0, 0, 0, 1'b1);
        idle(12);
        check("box16", bus.pixel_o, WR ? 25 : 16);
        pix_mode = -1;
        idle(50);

        pix_mode = 200;
        load_all(-1);
        step(1'b0, 0, 0, 1'b1);
        idle(12);
        check("neg_clamp", bus.pixel_o, WR ? 0 : 200);

        pix_mode = 255;
        load_all(0);
        step(1'b1, 12, 127, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        idle(12);
        check("pos_clamp", bus.pixel_o, 255);

        pix_mode = 10;
        step(1'b1, 12, 5, 1'b1);
        idle(12);
        check("race_old", bus.pixel_o, WR ? 79 : 10);
        step(1'b0, 0, 0, 1'b1);
        idle(12);
        check("race_new", bus.pixel_o, WR ? 3 : 10);

        step(1'b1, 25, 99, 1'b0);
        step(1'b1, 31, 99, 1'b0);
        step(1'b0, 0, 0, 1'b1);
        idle(12);
        check("bad_idx", bus.pixel_o, WR ? 3 : 10);

        pix_mode = -1;
        rand_coefs(300);

        pix_mode = 100; stat_mode = 1;
        idle(10);
        check("pre_rst_stat", bus.stat_o, 1);
        #2 rst = 1'b1;
        #1;
        check("async_pix", bus.pixel_o, 0);
        check("async_stat", bus.stat_o, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pix_mode = 50; stat_mode = -1;
        idle(12);
        check("post_rst_ident", bus.pixel_o, 50);

        pix_mode = -1;
        rand_coefs(150);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
